// File: rtl/parking_pkg.sv
// Shared definitions for the parking slot manager: default slot count,
// response codes and controller state encodings.
`ifndef PARKING_SLOTS
`define PARKING_SLOTS 8
`endif

package parking_pkg;

   localparam int PARKING_SLOTS = `PARKING_SLOTS;

   typedef enum logic [1:0] {
      RSP_OK            = 2'b00,
      RSP_ALREADY_OCC   = 2'b01,
      RSP_ALREADY_EMPTY = 2'b10,
      RSP_BAD_FLAT      = 2'b11
   } rsp_code_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // Index width that stays at least one bit wide for single-entry ranges.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/parking_slot_manager_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping around. The pointer register is owned by the parent.
module rr_arbiter
   import parking_pkg::*;
#(
   parameter int N = 2,
   parameter int W = idx_width(N)
)(
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx
);

   always_comb begin
      int   idx;
      logic found;
      // NOTE: every output of a combinational block gets a default up front,
      // otherwise paths that skip an assignment infer latches.
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = W'(idx);
         end
      end
   end

endmodule

// File: rtl/parking_slot_manager.sv
// Slot-occupancy keeper serving entry/exit requests from several gates,
// one transaction at a time, with a per-request result code.
module parking_slot_manager
   import parking_pkg::*;
#(
   parameter int N_SLOTS = `PARKING_SLOTS,
   parameter int N_GATES = 2,
   parameter int FW      = $clog2(N_SLOTS) + 1,
   parameter int GW      = idx_width(N_GATES),
   parameter int CW      = $clog2(N_SLOTS + 1)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_all,
   input  logic [N_GATES-1:0]    req_valid,
   input  logic [N_GATES-1:0]    req_exit,
   input  logic [N_GATES*FW-1:0] req_flat,
   output logic [N_GATES-1:0]    req_ready,
   output logic                  rsp_valid,
   output logic [GW-1:0]         rsp_gate,
   output logic [FW-1:0]         rsp_flat,
   output logic [1:0]            rsp_code,
   output logic [CW-1:0]         occ_count,
   output logic                  full,
   output logic                  empty
);

   localparam int SW = idx_width(N_SLOTS);

   state_t             state;
   logic [N_SLOTS-1:0] avail;
   logic [GW-1:0]      rr_ptr;
   logic [GW-1:0]      lat_gate;
   logic [FW-1:0]      lat_flat;
   logic               lat_exit;

   logic [N_GATES-1:0] grant;
   logic [GW-1:0]      grant_idx;
   logic [GW-1:0]      next_ptr;
   logic [FW-1:0]      sel_flat;
   logic               sel_exit;
   logic               accept;
   logic [SW-1:0]      slot;
   logic               slot_occ;
   logic               flat_bad;

   rr_arbiter #(
      .N (N_GATES),
      .W (GW)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Ready is gated by rst as well so it falls in the same cycle an
   // asynchronous reset arrives, not one edge later.
   assign req_ready = (state == ST_IDLE && !clr_all && !rst) ? grant : '0;
   assign accept    = |(req_valid & req_ready);
   assign next_ptr  = (grant_idx == GW'(N_GATES - 1)) ? '0 : grant_idx + GW'(1);

   always_comb begin
      sel_flat = '0;
      sel_exit = 1'b0;
      for (int g = 0; g < N_GATES; g++) begin
         if (grant[g]) begin
            sel_flat = req_flat[g*FW +: FW];
            sel_exit = req_exit[g];
         end
      end
   end

   assign slot     = lat_flat[SW-1:0];
   assign flat_bad = (lat_flat >= FW'(N_SLOTS));
   assign slot_occ = avail[slot];

   assign full  = (occ_count == CW'(N_SLOTS));
   assign empty = (occ_count == '0);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         avail     <= '0;
         occ_count <= '0;
         rr_ptr    <= '0;
         lat_gate  <= '0;
         lat_flat  <= '0;
         lat_exit  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_gate  <= '0;
         rsp_flat  <= '0;
         rsp_code  <= RSP_OK;
      end else if (clr_all) begin
         // Drop any in-flight request; the arbitration pointer is kept.
         state     <= ST_IDLE;
         avail     <= '0;
         occ_count <= '0;
         rsp_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  lat_gate <= grant_idx;
                  lat_flat <= sel_flat;
                  lat_exit <= sel_exit;
                  rr_ptr   <= next_ptr;
                  state    <= ST_EXEC;
               end
            end

            ST_EXEC: begin
               rsp_valid <= 1'b1;
               rsp_gate  <= lat_gate;
               rsp_flat  <= lat_flat;
               state     <= ST_RESP;
               // The count moves only when the slot bit actually flips.
               if (flat_bad) begin
                  rsp_code <= RSP_BAD_FLAT;
               end else if (!lat_exit) begin
                  if (slot_occ) begin
                     rsp_code <= RSP_ALREADY_OCC;
                  end else begin
                     avail[slot] <= 1'b1;
                     occ_count   <= occ_count + CW'(1);
                     rsp_code    <= RSP_OK;
                  end
               end else begin
                  if (slot_occ) begin
                     avail[slot] <= 1'b0;
                     occ_count   <= occ_count - CW'(1);
                     rsp_code    <= RSP_OK;
                  end else begin
                     rsp_code <= RSP_ALREADY_EMPTY;
                  end
               end
            end

            ST_RESP: begin
               rsp_valid <= 1'b0;
               state     <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_parking_slot_manager.sv
// Self-checking bench for parking_slot_manager: directed scenarios plus
// randomized multi-gate traffic checked against an occupancy model.
module tb_parking_slot_manager;

   localparam int N_SLOTS = 8;
   localparam int N_GATES = 2;
   localparam int FW      = 4;
   localparam int GW      = 1;
   localparam int CW      = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  clr_all;
   logic [N_GATES-1:0]    req_valid;
   logic [N_GATES-1:0]    req_exit;
   logic [N_GATES*FW-1:0] req_flat;
   logic [N_GATES-1:0]    req_ready;
   logic                  rsp_valid;
   logic [GW-1:0]         rsp_gate;
   logic [FW-1:0]         rsp_flat;
   logic [1:0]            rsp_code;
   logic [CW-1:0]         occ_count;
   logic                  full;
   logic                  empty;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t_acc = 0;

   // Reference model: one flag per slot plus the next-preferred gate.
   bit occ_m [N_SLOTS];
   int rr_m;

   parking_slot_manager #(
      .N_SLOTS (N_SLOTS),
      .N_GATES (N_GATES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr_all   (clr_all),
      .req_valid (req_valid),
      .req_exit  (req_exit),
      .req_flat  (req_flat),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_gate  (rsp_gate),
      .rsp_flat  (rsp_flat),
      .rsp_code  (rsp_code),
      .occ_count (occ_count),
      .full      (full),
      .empty     (empty)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int m_count();
      int c = 0;
      foreach (occ_m[i]) c += int'(occ_m[i]);
      return c;
   endfunction

   function automatic logic [1:0] m_apply(input bit ex, input int flat);
      if (flat >= N_SLOTS) return 2'b11;
      if (!ex) begin
         if (occ_m[flat]) return 2'b01;
         occ_m[flat] = 1'b1;
         return 2'b00;
      end
      if (!occ_m[flat]) return 2'b10;
      occ_m[flat] = 1'b0;
      return 2'b00;
   endfunction

   function automatic int m_pick(input logic [N_GATES-1:0] mask);
      for (int i = 0; i < N_GATES; i++) begin
         if (mask[(rr_m + i) % N_GATES]) return (rr_m + i) % N_GATES;
      end
      return -1;
   endfunction

   function automatic void m_clear();
      foreach (occ_m[i]) occ_m[i] = 1'b0;
   endfunction

   task automatic drive(input int g, input bit ex, input int flat);
      req_valid[g]         = 1'b1;
      req_exit[g]          = ex;
      req_flat[g*FW +: FW] = flat[FW-1:0];
   endtask

   // Waits (bounded) for a ready strobe, then completes the transfer edge.
   task automatic accept_one(output int g, output bit ok, output logic [N_GATES-1:0] rdy);
      g   = -1;
      ok  = 1'b0;
      rdy = '0;
      for (int k = 0; k < 20 && !ok; k++) begin
         #1;
         for (int i = 0; i < N_GATES; i++) begin
            if (req_ready[i] && !ok) begin
               g   = i;
               ok  = 1'b1;
               rdy = req_ready;
            end
         end
         if (!ok) @(negedge clk);
      end
      if (ok) begin
         @(posedge clk);
         #1;
         req_valid[g] = 1'b0;
         t_acc        = cyc;
      end
   endtask

   // Returns the number of falling edges after the accept until rsp_valid
   // is seen, or 0 if it never came.
   task automatic wait_rsp(output int lat);
      lat = 0;
      for (int k = 1; k <= 8 && lat == 0; k++) begin
         @(negedge clk);
         if (rsp_valid) lat = k;
      end
   endtask

   task automatic run_txn(input int g, input bit ex, input int flat);
      int ga, lat;
      bit ok;
      logic [N_GATES-1:0] rdy;
      logic [1:0] exp;
      drive(g, ex, flat);
      accept_one(ga, ok, rdy);
      total++;
      if (!ok || ga != g) begin
         bad++;
         $display("FAIL txn_accept got_gate=%0d ok=%0b exp_gate=%0d", ga, ok, g);
         req_valid = '0;
         return;
      end
      rr_m = (ga + 1) % N_GATES;
      exp  = m_apply(ex, flat);
      wait_rsp(lat);
      total++; if (lat != 2) begin bad++; $display("FAIL txn_latency got=%0d exp=2", lat); end
      total++; if (rsp_gate !== g[GW-1:0]) begin bad++; $display("FAIL txn_gate got=%0d exp=%0d", rsp_gate, g); end
      total++; if (rsp_flat !== flat[FW-1:0]) begin bad++; $display("FAIL txn_flat got=%0d exp=%0d", rsp_flat, flat); end
      total++; if (rsp_code !== exp) begin bad++; $display("FAIL txn_code flat=%0d exit=%0b got=%b exp=%b", flat, ex, rsp_code, exp); end
      total++; if (occ_count !== CW'(m_count())) begin bad++; $display("FAIL txn_count got=%0d exp=%0d", occ_count, m_count()); end
      total++; if (full !== (m_count() == N_SLOTS)) begin bad++; $display("FAIL txn_full got=%b count=%0d", full, m_count()); end
      total++; if (empty !== (m_count() == 0)) begin bad++; $display("FAIL txn_empty got=%b count=%0d", empty, m_count()); end
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      clr_all   = 1'b0;
      req_valid = '0;
      req_exit  = '0;
      req_flat  = '0;
      #2 rst = 1'b1;
      #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      total++; if (rsp_gate !== '0 || rsp_flat !== '0 || rsp_code !== 2'b00) begin bad++; $display("FAIL reset_rsp_fields got=%0d/%0d/%b exp=0/0/00", rsp_gate, rsp_flat, rsp_code); end
      total++; if (occ_count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", occ_count); end
      total++; if (full !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL reset_flags got full=%b empty=%b exp full=0 empty=1", full, empty); end
      req_valid = 2'b11;
      #1;
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_clear();
      rr_m = 0;
   endtask

   task automatic test_entry_exit();
      bit ex_tab [3] = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         run_txn(0, ex_tab[i], 3);
         @(negedge clk);
         total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL entry_exit_pulse step=%0d got=%b exp=0", i, rsp_valid); end
      end
      total++; if (rsp_code !== 2'b10 || occ_count !== '0) begin bad++; $display("FAIL entry_exit_final got code=%b count=%0d exp code=10 count=0", rsp_code, occ_count); end
   endtask

   task automatic test_arbitration();
      int g0, g1, exp_g, lat, t0;
      bit ok;
      logic [N_GATES-1:0] rdy;
      logic [1:0] exp;
      int first_tab [2] = '{0, 1};
      // Steer the pointer so pass 0 starts at gate 0 and pass 1 at gate 1.
      run_txn(1, 1'b1, 5);
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) run_txn(0, 1'b0, 6);
         drive(0, pass[0], 1);
         drive(1, pass[0], 2);
         exp_g = m_pick(2'b11);
         accept_one(g0, ok, rdy);
         t0 = t_acc;
         total++; if (!ok || g0 != first_tab[pass] || g0 != exp_g) begin bad++; $display("FAIL arb_first pass=%0d got=%0d exp=%0d", pass, g0, first_tab[pass]); end
         total++; if (rdy !== 2'(1 << exp_g)) begin bad++; $display("FAIL arb_onehot pass=%0d got=%b", pass, rdy); end
         if (!ok) begin req_valid = '0; return; end
         rr_m = (g0 + 1) % N_GATES;
         exp  = m_apply(pass[0], g0 + 1);
         wait_rsp(lat);
         total++; if (lat != 2 || rsp_gate !== g0[GW-1:0] || rsp_code !== exp) begin bad++; $display("FAIL arb_rsp1 pass=%0d got lat=%0d gate=%0d code=%b exp lat=2 gate=%0d code=%b", pass, lat, rsp_gate, rsp_code, g0, exp); end
         accept_one(g1, ok, rdy);
         total++; if (!ok || g1 != 1 - g0) begin bad++; $display("FAIL arb_second pass=%0d got=%0d exp=%0d", pass, g1, 1 - g0); end
         total++; if (t_acc - t0 != 3) begin bad++; $display("FAIL arb_spacing pass=%0d got=%0d exp=3", pass, t_acc - t0); end
         if (!ok) begin req_valid = '0; return; end
         rr_m = (g1 + 1) % N_GATES;
         exp  = m_apply(pass[0], g1 + 1);
         wait_rsp(lat);
         total++; if (lat != 2 || rsp_gate !== g1[GW-1:0] || rsp_flat !== FW'(g1 + 1) || rsp_code !== exp) begin bad++; $display("FAIL arb_rsp2 pass=%0d got gate=%0d flat=%0d code=%b exp gate=%0d code=%b", pass, rsp_gate, rsp_flat, rsp_code, g1, exp); end
         total++; if (occ_count !== CW'(m_count())) begin bad++; $display("FAIL arb_count pass=%0d got=%0d exp=%0d", pass, occ_count, m_count()); end
      end
   endtask

   task automatic test_fill_bad();
      for (int f = 0; f < N_SLOTS; f++) run_txn(int'($urandom_range(0, 1)), 1'b0, f);
      total++; if (full !== 1'b1 || occ_count !== CW'(N_SLOTS)) begin bad++; $display("FAIL fill_full got full=%b count=%0d exp full=1 count=8", full, occ_count); end
      run_txn(int'($urandom_range(0, 1)), 1'b0, 0);
      total++; if (rsp_code !== 2'b01) begin bad++; $display("FAIL fill_reentry got=%b exp=01", rsp_code); end
      run_txn(0, 1'b0, 8);
      total++; if (rsp_code !== 2'b11 || occ_count !== CW'(N_SLOTS)) begin bad++; $display("FAIL fill_bad_flat got code=%b count=%0d exp code=11 count=8", rsp_code, occ_count); end
   endtask

   task automatic test_clr_exec();
      int g;
      bit ok, seen;
      logic [N_GATES-1:0] rdy;
      drive(0, 1'b0, 4);
      accept_one(g, ok, rdy);
      total++; if (!ok || g != 0) begin bad++; $display("FAIL clr_accept got=%0d exp=0", g); end
      if (ok) rr_m = (g + 1) % N_GATES;
      clr_all = 1'b1;
      @(posedge clk);
      #1 clr_all = 1'b0;
      m_clear();
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL clr_dropped got rsp_valid=1 exp=0"); end
      total++; if (occ_count !== '0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL clr_state got count=%0d empty=%b full=%b exp 0/1/0", occ_count, empty, full); end
      drive(1, 1'b0, 5);
      clr_all = 1'b1;
      #1;
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL clr_blocks_ready got=%b exp=00", req_ready); end
      @(posedge clk);
      #1 clr_all = 1'b0;
      run_txn(1, 1'b0, 5);
   endtask

   task automatic test_async_rst();
      int g, lat;
      bit ok;
      logic [N_GATES-1:0] rdy;
      logic [1:0] exp;
      drive(0, 1'b0, 7);
      accept_one(g, ok, rdy);
      total++; if (!ok || g != 0) begin bad++; $display("FAIL arst_accept got=%0d exp=0", g); end
      if (!ok) begin req_valid = '0; return; end
      exp = m_apply(1'b0, 7);
      wait_rsp(lat);
      total++; if (lat != 2 || rsp_code !== exp) begin bad++; $display("FAIL arst_resp got lat=%0d code=%b exp lat=2 code=%b", lat, rsp_code, exp); end
      drive(1, 1'b1, 7);
      #2 rst = 1'b1;
      #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL arst_rsp_drop got=%b exp=0", rsp_valid); end
      total++; if (occ_count !== '0 || empty !== 1'b1) begin bad++; $display("FAIL arst_count got count=%0d empty=%b exp 0/1", occ_count, empty); end
      total++; if (req_ready !== 2'b00 || rsp_code !== 2'b00) begin bad++; $display("FAIL arst_outputs got ready=%b code=%b exp 00/00", req_ready, rsp_code); end
      @(negedge clk);
      #2 rst = 1'b0;
      m_clear();
      rr_m = 0;
      run_txn(1, 1'b1, 7);
   endtask

   task automatic test_back_to_back();
      bit pend [N_GATES];
      bit pex [N_GATES];
      int pfl [N_GATES];
      logic [N_GATES-1:0] mask, rdy;
      logic [1:0] exp;
      int g, exp_g, lat;
      bit ok;
      foreach (pend[i]) pend[i] = 1'b0;
      for (int it = 0; it < 80; it++) begin
         for (int i = 0; i < N_GATES; i++) begin
            if (!pend[i] && $urandom_range(0, 2) != 0) begin
               pend[i] = 1'b1;
               pex[i]  = ($urandom_range(0, 9) < 4);
               pfl[i]  = int'($urandom_range(0, 9));
               drive(i, pex[i], pfl[i]);
            end
         end
         mask = '0;
         for (int i = 0; i < N_GATES; i++) mask[i] = pend[i];
         if (mask == '0) begin
            pend[0] = 1'b1;
            pex[0]  = 1'b0;
            pfl[0]  = int'($urandom_range(0, 9));
            drive(0, pex[0], pfl[0]);
            mask[0] = 1'b1;
         end
         exp_g = m_pick(mask);
         accept_one(g, ok, rdy);
         total++; if (!ok || g != exp_g) begin bad++; $display("FAIL b2b_grant it=%0d mask=%b got=%0d exp=%0d", it, mask, g, exp_g); end
         if (!ok) begin req_valid = '0; return; end
         pend[g] = 1'b0;
         rr_m    = (g + 1) % N_GATES;
         exp     = m_apply(pex[g], pfl[g]);
         wait_rsp(lat);
         total++; if (lat != 2 || rsp_gate !== g[GW-1:0] || rsp_flat !== pfl[g][FW-1:0]) begin bad++; $display("FAIL b2b_rsp it=%0d got lat=%0d gate=%0d flat=%0d exp lat=2 gate=%0d flat=%0d", it, lat, rsp_gate, rsp_flat, g, pfl[g]); end
         total++; if (rsp_code !== exp) begin bad++; $display("FAIL b2b_code it=%0d got=%b exp=%b", it, rsp_code, exp); end
         total++; if (occ_count !== CW'(m_count()) || full !== (m_count() == N_SLOTS) || empty !== (m_count() == 0)) begin bad++; $display("FAIL b2b_count it=%0d got=%0d full=%b empty=%b exp=%0d", it, occ_count, full, empty, m_count()); end
      end
      req_valid = '0;
   endtask

   initial begin
      test_reset();
      test_entry_exit();
      test_arbitration();
      test_fill_bad();
      test_clr_exec();
      test_async_rst();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/parking_slot_manager.md
# parking_slot_manager

Synthesisable, clocked successor to the file-based slot-exit check. Holds one availability bit per flat's parking slot and serves entry and exit requests from `N_GATES` independent gates through a round-robin arbiter and valid/ready handshake. Reports a per-transaction result code and maintains a live occupancy count with full/empty flags. Sits between the gate controllers and the society display/logging logic.

## Interface
- `N_SLOTS`, default `` `parking_slots ``, number of slots; flats `0..N_SLOTS-1`
- `N_GATES`, default 2, number of requesting gates (1..8)
- `FW`, default `$clog2(N_SLOTS)+1`, flat-number width
- `GW`, default `max(1,$clog2(N_GATES))`, gate-index width
- `CW`, default `$clog2(N_SLOTS+1)`, count width

- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `clr_all`  in  1  synchronous clear of every slot
- `req_valid`  in  N_GATES  request pending per gate
- `req_exit`  in  N_GATES  0 = entry, 1 = exit
- `req_flat`  in  N_GATES*FW  flat number per gate, gate g at `[g*FW +: FW]`
- `req_ready`  out  N_GATES  accept strobe per gate
- `rsp_valid`  out  1  one-cycle result pulse
- `rsp_gate`  out  GW  gate that issued the answered request
- `rsp_flat`  out  FW  flat number of the answered request
- `rsp_code`  out  2  result: 00 OK, 01 ALREADY_OCC, 10 ALREADY_EMPTY, 11 BAD_FLAT
- `occ_count`  out  CW  number of occupied slots
- `full`  out  1  `occ_count == N_SLOTS`
- `empty`  out  1  `occ_count == 0`

## Operation
- State: `avail[N_SLOTS-1:0]` (1 = occupied); `occ_count`; round-robin pointer `rr_ptr`; FSM IDLE → EXEC → RESP → IDLE.
- IDLE:
  - The arbiter picks the first gate with `req_valid`, searching from `rr_ptr` upward with wrap-around.
  - `req_ready[g]` is driven high combinationally only for that gate, only in IDLE, and only when `clr_all` is low.
  - Transfer occurs when `req_valid[g] & req_ready[g]`. On transfer, latch gate, flat and type; set `rr_ptr = g+1` (wraps to 0); go to EXEC.
- EXEC: evaluate the latched request.
  - Flat ≥ N_SLOTS → BAD_FLAT; no state change.
  - Entry, slot free → set bit, count+1, OK.
  - Entry, slot occupied → ALREADY_OCC; no change.
  - Exit, slot occupied → clear bit, count−1, OK.
  - Exit, slot empty → ALREADY_EMPTY; no change.
- RESP: `rsp_valid = 1` for exactly one cycle with latched gate/flat and registered code. Return to IDLE.
- `rsp_gate`, `rsp_flat` and `rsp_code` hold their last values until the next response.
- `clr_all`:
  - Highest priority after `rst`.
  - Zeroes `avail` and `occ_count` and forces IDLE.
  - Any in-flight transaction is dropped with no response.
  - No request is accepted in a cycle where `clr_all` is high.
  - `rr_ptr` is unchanged.
- Count never wraps: an update is only applied when the bit actually toggles, so the count stays in `0..N_SLOTS`.
- Reset values: every output 0 except `empty = 1`; `avail = 0`, `rr_ptr = 0`, state IDLE.

## Timing
- Accept at cycle t; the `avail`/count update is visible at t+2; `rsp_valid` is high during t+2.
- Throughput: one transaction per 3 cycles. The next accept is possible at t+3.
- `full` and `empty` are combinational from registered `occ_count`.
- Asynchronous `rst` mid-transaction: state returns to reset values immediately, no response is issued, and `req_ready` goes low in the same cycle.
- A requester must hold `req_valid`, `req_exit` and `req_flat` stable until it sees `req_ready`.

## Structure
- Shared package/header `parking_pkg`:
  - `` `parking_slots ``
  - response-code constants `RSP_OK`, `RSP_ALREADY_OCC`, `RSP_ALREADY_EMPTY`, `RSP_BAD_FLAT`
  - FSM state encodings
- Sub-module `rr_arbiter #(N)`:
  - inputs `req`, `ptr`
  - outputs one-hot `grant`, `grant_idx`
  - purely combinational; the pointer register lives in the parent.

## Test plan
- **Reset:** assert `rst` asynchronously → all outputs 0, `empty = 1`, `req_ready = 0`.
- **Entry then exit** (N_SLOTS=8, N_GATES=2):
  - Gate0 entry flat 3 accepted at t → `rsp_valid` at t+2, gate 0, flat 3, code 00, `occ_count = 1`.
  - Gate0 exit flat 3 → code 00, count 0.
  - Repeated exit of flat 3 → code 10, count stays 0.
- **Arbitration:**
  - Gates 0 and 1 both request entry (flats 1 and 2) in the same cycle → gate 0 accepted first, gate 1 accepted 3 cycles later.
  - Next simultaneous pair → gate 1 wins first.
- **Fill and bad flat:**
  - Enter flats 0..7 → `full = 1` after the eighth response.
  - Entry of flat 0 again → code 01.
  - Flat 8 → code 11, count unchanged.
- **clr_all during EXEC:** no `rsp_valid`, `occ_count = 0`, `empty = 1`; the next request is accepted normally.
- **Async `rst` pulse in RESP state:** `rsp_valid` drops immediately and `avail` is cleared.
